// File: rtl/bot_update_ctrl.sv
// Rojobot-to-core status update sequencer: snapshots bot registers, raises an update flag, waits for ack.
// Optional BOT_STOP_ON_TIMEOUT_EN: clear the motor command when the core fails to ack in time.
module bot_update_ctrl #(
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int MISS_W         = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_upd_sysregs,
  input  logic [7:0]        i_locx,
  input  logic [7:0]        i_locy,
  input  logic [7:0]        i_sensors,
  input  logic [7:0]        i_botinfo,
  input  logic              i_int_ack,
  input  logic              i_motctl_wr,
  input  logic [7:0]        i_motctl_data,
  input  logic              i_clr_status,
  output logic [7:0]        o_motctl,
  output logic [31:0]       o_bot_info,
  output logic              o_upd_flag,
  output logic [MISS_W-1:0] o_miss_cnt,
  output logic              o_timeout,
  output logic              o_busy
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, PEND, ACK_LOW} state_t;

  state_t             state, state_n;
  logic               upd_q;
  logic               upd_evt;
  logic               pend, pend_n;
  logic [TMR_W-1:0]   timer, timer_n;
  logic               flag_n;
  logic               timeout_n;
  logic               timeout_hit;
  logic [MISS_W-1:0]  miss_n;
  logic [31:0]        info_n;
  logic [7:0]         motctl_n;

  assign upd_evt = i_upd_sysregs & ~upd_q;
  assign o_busy  = (state != IDLE);

  always_comb begin
    state_n     = state;
    pend_n      = pend;
    timer_n     = timer;
    flag_n      = o_upd_flag;
    timeout_n   = o_timeout;
    timeout_hit = 1'b0;
    miss_n      = o_miss_cnt;
    info_n      = o_bot_info;
    motctl_n    = o_motctl;

    case (state)
      IDLE: begin
        // A fresh event and a queued one are served together as one snapshot.
        if (upd_evt || pend) begin
          info_n  = {i_locx, i_locy, i_sensors, i_botinfo};
          pend_n  = 1'b0;
          timer_n = '0;
          flag_n  = 1'b1;
          state_n = PEND;
        end
      end
      PEND: begin
        timer_n = timer + TMR_W'(1);
        if (i_int_ack) begin
          flag_n  = 1'b0;
          state_n = ACK_LOW;
        end else if (timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          flag_n      = 1'b0;
          timeout_hit = 1'b1;
          state_n     = IDLE;
        end
      end
      ACK_LOW: begin
        if (!i_int_ack) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // One-deep queue while busy; further events are counted as lost.
    if (upd_evt && (state != IDLE)) begin
      if (!pend) pend_n = 1'b1;
      else if (o_miss_cnt != '1) miss_n = o_miss_cnt + MISS_W'(1);
    end

    if (timeout_hit) timeout_n = 1'b1;

`ifdef BOT_STOP_ON_TIMEOUT_EN
    if (timeout_hit) motctl_n = 8'h00;
`endif
    if (i_motctl_wr) motctl_n = i_motctl_data;

    if (i_clr_status) begin
      timeout_n = 1'b0;
      miss_n    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      upd_q      <= 1'b0;
      pend       <= 1'b0;
      timer      <= '0;
      o_upd_flag <= 1'b0;
      o_timeout  <= 1'b0;
      o_miss_cnt <= '0;
      o_bot_info <= '0;
      o_motctl   <= '0;
    end else begin
      state      <= state_n;
      upd_q      <= i_upd_sysregs;
      pend       <= pend_n;
      timer      <= timer_n;
      o_upd_flag <= flag_n;
      o_timeout  <= timeout_n;
      o_miss_cnt <= miss_n;
      o_bot_info <= info_n;
      o_motctl   <= motctl_n;
    end
  end

endmodule

// File: tb/tb_bot_update_ctrl.sv
// Self-checking bench for bot_update_ctrl: vector table for snapshot handshakes plus
// hand-written sequences for queueing, timeout, clear priority and reset.
module tb_bot_update_ctrl;

  localparam int TOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        upd, ack, clr, mwr;
  logic [7:0]  locx, locy, sens, binfo, mdata;
  logic [7:0]  motctl;
  logic [31:0] bot_info;
  logic        flag, timeout, busy;
  logic [7:0]  miss;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [7:0]  lx, ly, se, bi;
    int          ack_delay;
    logic [31:0] exp_info;
  } vec_t;
  vec_t vecs[4];

  bot_update_ctrl #(.TIMEOUT_CYCLES(TOUT), .MISS_W(8)) dut (
    .clk(clk), .rst(rst), .i_upd_sysregs(upd),
    .i_locx(locx), .i_locy(locy), .i_sensors(sens), .i_botinfo(binfo),
    .i_int_ack(ack), .i_motctl_wr(mwr), .i_motctl_data(mdata), .i_clr_status(clr),
    .o_motctl(motctl), .o_bot_info(bot_info), .o_upd_flag(flag),
    .o_miss_cnt(miss), .o_timeout(timeout), .o_busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic u, input logic a, input logic c);
    upd = u;
    ack = a;
    clr = c;
    tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setInputs(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    locx = a; locy = b; sens = c; binfo = d;
  endtask

  // Wait (bounded) for the update flag, then compare the snapshot with the scoreboard head.
  task automatic waitFlag(input string name, input int bound);
    int n = 0;
    logic [31:0] exp;
    while (!flag && n < bound) begin
      tick();
      n++;
    end
    if (!flag) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: flag not seen within %0d cycles", name, bound);
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s: unexpected flag, scoreboard empty, got %h", name, bot_info);
    end else begin
      exp = sb.pop_front();
      checkOutput(name, bot_info, exp);
    end
  endtask

  initial begin
    vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 0, 32'h01020304};
    vecs[1] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 3, 32'hFF00FF00};
    vecs[2] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 7, 32'hA55A3CC3};
    vecs[3] = '{8'h80, 8'h7F, 8'h01, 8'hFE, 1, 32'h807F01FE};

    rst = 1'b1; upd = 0; ack = 0; clr = 0; mwr = 0; mdata = 0;
    setInputs(8'h00, 8'h00, 8'h00, 8'h00);
    tick(); tick();
    checkOutput("rst_flag", {31'd0, flag}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_miss", {24'd0, miss}, 32'd0);
    checkOutput("rst_info", bot_info, 32'd0);
    rst = 1'b0;
    tick();

    // Test 1: first snapshot, one-cycle latency
    setInputs(8'd12, 8'd34, 8'd56, 8'd78);
    sb.push_back(32'h0C22384E);
    applyStimulus(1, 0, 0);
    checkOutput("t1_flag_latency", {31'd0, flag}, 32'd1);
    checkOutput("t1_busy", {31'd0, busy}, 32'd1);
    waitFlag("t1_info", 1);

    // Test 2: ack held 3 cycles, level update held high is a single event
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
    checkOutput("t2_flag_hold", {31'd0, flag}, 32'd1);
    applyStimulus(1, 1, 0);
    checkOutput("t2_flag_drop", {31'd0, flag}, 32'd0);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 1, 0);
    checkOutput("t2_acklow_busy", {31'd0, busy}, 32'd1);
    applyStimulus(1, 0, 0);
    checkOutput("t2_idle", {31'd0, busy}, 32'd0);
    applyStimulus(1, 0, 0);
    checkOutput("t2_no_reflag", {31'd0, flag}, 32'd0);
    checkOutput("t2_miss", {24'd0, miss}, 32'd0);
    applyStimulus(0, 0, 0);

    // Vector table: snapshot contents across patterns and ack delays
    foreach (vecs[k]) begin
      setInputs(vecs[k].lx, vecs[k].ly, vecs[k].se, vecs[k].bi);
      sb.push_back(vecs[k].exp_info);
      applyStimulus(1, 0, 0);
      applyStimulus(0, 0, 0);
      waitFlag($sformatf("vec%0d_info", k), 2);
      for (int d = 0; d < vecs[k].ack_delay; d++) applyStimulus(0, 0, 0);
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("vec%0d_flag_drop", k), {31'd0, flag}, 32'd0);
      applyStimulus(0, 0, 0);
      checkOutput($sformatf("vec%0d_idle", k), {31'd0, busy}, 32'd0);
    end

    // Test 3: three edges while pending -> one queued, two missed
    setInputs(8'h11, 8'h22, 8'h33, 8'h44);
    sb.push_back(32'h11223344);
    applyStimulus(1, 0, 0);
    waitFlag("t3_first", 1);
    for (int i = 0; i < 3; i++) begin
      locx = 8'hA1 + 8'(i);
      applyStimulus(0, 0, 0);
      applyStimulus(1, 0, 0);
    end
    applyStimulus(0, 0, 0);
    checkOutput("t3_miss", {24'd0, miss}, 32'd2);
    checkOutput("t3_info_stable", bot_info, 32'h11223344);
    applyStimulus(0, 1, 0);
    checkOutput("t3_flag_drop", {31'd0, flag}, 32'd0);
    sb.push_back(32'hA3223344);
    applyStimulus(0, 0, 0);
    checkOutput("t3_no_snap_yet", {31'd0, flag}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_queued_flag", {31'd0, flag}, 32'd1);
    waitFlag("t3_second", 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    checkOutput("t3_miss_kept", {24'd0, miss}, 32'd2);

    // Test 4: timeout after TOUT cycles, motor stop option, status clear
    applyStimulus(0, 0, 1);
    checkOutput("t4_clr_miss", {24'd0, miss}, 32'd0);
    mwr = 1; mdata = 8'h33;
    applyStimulus(0, 0, 0);
    mwr = 0;
    checkOutput("t4_motctl_wr", {24'd0, motctl}, 32'h33);
    setInputs(8'h55, 8'h66, 8'h77, 8'h88);
    sb.push_back(32'h55667788);
    applyStimulus(1, 0, 0);
    waitFlag("t4_info", 1);
    for (int i = 0; i < TOUT - 1; i++) applyStimulus(0, 0, 0);
    checkOutput("t4_flag_before_tout", {31'd0, flag}, 32'd1);
    checkOutput("t4_no_tout_yet", {31'd0, timeout}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t4_flag_tout", {31'd0, flag}, 32'd0);
    checkOutput("t4_timeout", {31'd0, timeout}, 32'd1);
    checkOutput("t4_idle", {31'd0, busy}, 32'd0);
`ifdef BOT_STOP_ON_TIMEOUT_EN
    checkOutput("t4_motctl", {24'd0, motctl}, 32'h00);
`else
    checkOutput("t4_motctl", {24'd0, motctl}, 32'h33);
`endif
    applyStimulus(0, 0, 1);
    checkOutput("t4_clr_tout", {31'd0, timeout}, 32'd0);
    applyStimulus(0, 0, 0);

    // Test 5a: ack and timeout in the same cycle -> ack wins
    sb.push_back(32'h55667788);
    applyStimulus(1, 0, 0);
    waitFlag("t5_info", 1);
    for (int i = 0; i < TOUT - 1; i++) applyStimulus(0, 0, 0);
    applyStimulus(0, 1, 0);
    checkOutput("t5_ack_wins_tout", {31'd0, timeout}, 32'd0);
    checkOutput("t5_acklow", {31'd0, busy}, 32'd1);
    checkOutput("t5_flag_drop", {31'd0, flag}, 32'd0);
    applyStimulus(0, 0, 0);
    checkOutput("t5_idle", {31'd0, busy}, 32'd0);

    // Test 5b: clear beats a same-cycle miss increment, leaving pend set for test 6
    sb.push_back(32'h55667788);
    applyStimulus(1, 0, 0);
    waitFlag("t5b_info", 1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 0);
    checkOutput("t5b_miss_one", {24'd0, miss}, 32'd1);
    applyStimulus(0, 0, 0);
    applyStimulus(1, 0, 1);
    checkOutput("t5b_clr_beats_inc", {24'd0, miss}, 32'd0);

    // Test 6: reset mid-PEND discards pend and snapshot
    upd = 0; clr = 0; ack = 0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t6_flag", {31'd0, flag}, 32'd0);
    checkOutput("t6_busy", {31'd0, busy}, 32'd0);
    checkOutput("t6_info", bot_info, 32'd0);
    checkOutput("t6_motctl", {24'd0, motctl}, 32'd0);
    checkOutput("t6_tout", {31'd0, timeout}, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0);
    checkOutput("t6_no_stale_flag", {31'd0, flag}, 32'd0);
    setInputs(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    sb.push_back(32'hDEADBEEF);
    applyStimulus(1, 0, 0);
    waitFlag("t6_single", 1);
    applyStimulus(1, 1, 0);
    applyStimulus(1, 0, 0);
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0);
    checkOutput("t6_one_flag_only", {30'd0, flag, busy}, 32'd0);
    checkOutput("t6_sb_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
